block_sprite_renderer: RTL and testbench

BLOCK_SPRITE_RENDERER -- requirements
Module: block_sprite_renderer

---
 rtl/bsr_pkg.sv | 25 ++
 rtl/bsr_hit_cmp.sv | 25 ++
 rtl/block_sprite_renderer.sv | 238 +++++++++++++++++++++++
 tb/tb_block_sprite_renderer.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsr_pkg.sv
// Shared type codes and image-layout constants for the block sprite renderer.
// Optional collision tracking is enabled with the BSR_COLLISION_EN macro.
package bsr_pkg;

    typedef enum logic [2:0] {
        BLUE   = 3'd0,
        ORANGE = 3'd1,
        YELLOW = 3'd2,
        GREEN  = 3'd3,
        BROWN  = 3'd4,
        NONE   = 3'd5
    } blk_type_e;

    localparam int BG_IN  = 62400;
    localparam int BG_OUT = 115200;

    // Sprite sheet rows: doodle frames start at row 60, platforms are 12 rows each.
    localparam int DOODLE_ROW = 60;
    localparam int PLAT_ROW   = 12;

    function automatic logic type_valid(input logic [2:0] t);
        return t <= 3'(BROWN);
    endfunction

endpackage

// File: rtl/bsr_hit_cmp.sv
// Inclusive range compare of the scan position against one platform slot.
// Sums use 11 bits so a slot near the right/bottom edge never wraps.
module bsr_hit_cmp #(
    parameter int BLOCK_W = 32,
    parameter int BLOCK_H = 10
) (
    input  logic       occ,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [9:0] h,
    input  logic [9:0] v,
    output logic       hit
);

    logic [10:0] x_end;
    logic [10:0] y_end;

    assign x_end = {1'b0, x} + 11'(BLOCK_W);
    assign y_end = {1'b0, y} + 11'(BLOCK_H);

    assign hit = occ
               && (h >= x) && ({1'b0, h} <= x_end)
               && (v >= y) && ({1'b0, v} <= y_end);

endmodule

// File: rtl/block_sprite_renderer.sv
// Two-stage platform/doodle pixel renderer with double-buffered slot table.
// Define BSR_COLLISION_EN to add the sticky collide/collide_idx outputs.
module block_sprite_renderer
    import bsr_pkg::*;
#(
    parameter int NUM_BLOCKS = 16,
    parameter int BLOCK_W    = 32,
    parameter int BLOCK_H    = 10,
    parameter int SPR_W      = 39,
    parameter int SPR_H      = 39,
    parameter int PIC_W      = 480,
    parameter int ADDR_W     = 17,
    parameter int SCREEN_L   = 200,
    parameter int SCREEN_R   = 440,
    localparam int IDXW      = $clog2(NUM_BLOCKS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              game_en,
    input  logic              wr_en,
    input  logic [IDXW-1:0]   wr_idx,
    input  logic [9:0]        wr_x,
    input  logic [9:0]        wr_y,
    input  logic [2:0]        wr_type,
    input  logic              wr_vld,
    output logic              wr_ready,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic [9:0]        doodle_x,
    input  logic [9:0]        doodle_y,
    input  logic              invincible,
    input  logic              doodle_right,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [2:0]        detect,
    output logic              detect_doodle
`ifdef BSR_COLLISION_EN
    ,
    output logic              collide,
    output logic [IDXW-1:0]   collide_idx
`endif
);

    logic [9:0]            sh_x [NUM_BLOCKS];
    logic [9:0]            sh_y [NUM_BLOCKS];
    logic [2:0]            sh_t [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] sh_occ;
    logic [9:0]            act_x [NUM_BLOCKS];
    logic [9:0]            act_y [NUM_BLOCKS];
    logic [2:0]            act_t [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] act_occ;

    logic wr_ok;

    assign wr_ready = !frame_start;
    assign wr_ok    = wr_en && wr_ready && (32'(wr_idx) < 32'(NUM_BLOCKS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_occ  <= '0;
            act_occ <= '0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                sh_x[i]  <= '0;
                sh_y[i]  <= '0;
                sh_t[i]  <= '0;
                act_x[i] <= '0;
                act_y[i] <= '0;
                act_t[i] <= '0;
            end
        end else begin
            if (wr_ok) begin
                sh_x[wr_idx]   <= wr_x;
                sh_y[wr_idx]   <= wr_y;
                sh_t[wr_idx]   <= wr_type;
                sh_occ[wr_idx] <= wr_vld && type_valid(wr_type);
            end
            // Writes are blocked on this cycle, so the copy sees settled shadow data.
            if (frame_start) begin
                act_occ <= sh_occ;
                for (int i = 0; i < NUM_BLOCKS; i++) begin
                    act_x[i] <= sh_x[i];
                    act_y[i] <= sh_y[i];
                    act_t[i] <= sh_t[i];
                end
            end
        end
    end

    logic [NUM_BLOCKS-1:0] hit;

    for (genvar g = 0; g < NUM_BLOCKS; g++) begin : g_cmp
        bsr_hit_cmp #(
            .BLOCK_W (BLOCK_W),
            .BLOCK_H (BLOCK_H)
        ) u_cmp (
            .occ (act_occ[g]),
            .x   (act_x[g]),
            .y   (act_y[g]),
            .h   (h_cnt),
            .v   (v_cnt),
            .hit (hit[g])
        );
    end

    logic [10:0] dx_end;
    logic [10:0] dy_end;
    logic        dhit;

    assign dx_end = {1'b0, doodle_x} + 11'(SPR_W);
    assign dy_end = {1'b0, doodle_y} + 11'(SPR_H);
    assign dhit   = (h_cnt >= doodle_x) && ({1'b0, h_cnt} < dx_end)
                 && (v_cnt >= doodle_y) && ({1'b0, v_cnt} < dy_end);

    logic [9:0]            s1_h;
    logic [9:0]            s1_v;
    logic [9:0]            s1_dx;
    logic [9:0]            s1_dy;
    logic [NUM_BLOCKS-1:0] s1_hit;
    logic                  s1_dhit;
    logic                  s1_inv;
    logic                  s1_right;
    logic                  s1_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_h     <= '0;
            s1_v     <= '0;
            s1_dx    <= '0;
            s1_dy    <= '0;
            s1_hit   <= '0;
            s1_dhit  <= 1'b0;
            s1_inv   <= 1'b0;
            s1_right <= 1'b0;
            s1_en    <= 1'b0;
        end else begin
            s1_h     <= h_cnt;
            s1_v     <= v_cnt;
            s1_dx    <= doodle_x;
            s1_dy    <= doodle_y;
            s1_hit   <= hit;
            s1_dhit  <= dhit;
            s1_inv   <= invincible;
            s1_right <= doodle_right;
            s1_en    <= game_en;
        end
    end

    logic [IDXW-1:0] sel;
    logic            any;

    always_comb begin
        sel = '0;
        any = 1'b0;
        for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
            if (s1_hit[i]) begin
                sel = IDXW'(i);
                any = 1'b1;
            end
        end
    end

    logic              in_field;
    logic [2:0]        plat_type;
    logic [31:0]       d_col;
    logic [31:0]       p_off;
    logic [31:0]       d_off;
    logic [ADDR_W-1:0] addr_d;
    logic [2:0]        det_d;
    logic              dd_d;

    assign in_field  = (s1_h >= 10'(SCREEN_L)) && (s1_h <= 10'(SCREEN_R));
    assign plat_type = any ? act_t[sel] : 3'(NONE);

    // Invincible frame sits between the right- and left-facing frames.
    assign d_col = s1_inv   ? 32'(SPR_W)
                 : s1_right ? 32'd0
                 :            32'(2 * SPR_W);

    assign p_off = 32'(s1_h) - 32'(act_x[sel])
                 + (32'(s1_v) - 32'(act_y[sel])) * 32'(PIC_W)
                 + 32'(PIC_W * PLAT_ROW) * 32'(act_t[sel]);

    assign d_off = 32'(s1_h) - 32'(s1_dx)
                 + (32'(s1_v) - 32'(s1_dy)) * 32'(PIC_W)
                 + 32'(PIC_W * DOODLE_ROW) + d_col;

    always_comb begin
        addr_d = ADDR_W'(BG_OUT);
        det_d  = 3'(NONE);
        dd_d   = 1'b0;
        if (!s1_en) begin
            addr_d = in_field ? ADDR_W'(BG_IN) : ADDR_W'(BG_OUT);
        end else if (!in_field) begin
            det_d = plat_type;
        end else if (s1_dhit) begin
            addr_d = d_off[ADDR_W-1:0];
            det_d  = plat_type;
            dd_d   = 1'b1;
        end else if (any) begin
            addr_d = p_off[ADDR_W-1:0];
            det_d  = plat_type;
        end else begin
            addr_d = ADDR_W'(BG_IN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_addr    <= ADDR_W'(BG_OUT);
            detect        <= 3'(NONE);
            detect_doodle <= 1'b0;
        end else begin
            pixel_addr    <= addr_d;
            detect        <= det_d;
            detect_doodle <= dd_d;
        end
    end

`ifdef BSR_COLLISION_EN
    logic coll_set;

    assign coll_set = s1_en && in_field && s1_dhit && any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collide     <= 1'b0;
            collide_idx <= '0;
        end else if (frame_start) begin
            collide     <= 1'b0;
            collide_idx <= '0;
        end else if (coll_set && !collide) begin
            collide     <= 1'b1;
            collide_idx <= sel;
        end
    end
`endif

endmodule

// File: tb/tb_block_sprite_renderer.sv
// Scoreboard bench for block_sprite_renderer (default 16 slots, 480-pixel pitch).
// Collision checks are compiled in when BSR_COLLISION_EN is defined.
module tb_block_sprite_renderer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        game_en = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_idx = '0;
    logic [9:0]  wr_x = '0;
    logic [9:0]  wr_y = '0;
    logic [2:0]  wr_type = '0;
    logic        wr_vld = 1'b0;
    logic        wr_ready;
    logic [9:0]  h_cnt = '0;
    logic [9:0]  v_cnt = '0;
    logic [9:0]  doodle_x = 10'd900;
    logic [9:0]  doodle_y = 10'd900;
    logic        invincible = 1'b0;
    logic        doodle_right = 1'b1;
    logic [16:0] pixel_addr;
    logic [2:0]  detect;
    logic        detect_doodle;
`ifdef BSR_COLLISION_EN
    logic        collide;
    logic [3:0]  collide_idx;
`endif

    block_sprite_renderer dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .game_en       (game_en),
        .wr_en         (wr_en),
        .wr_idx        (wr_idx),
        .wr_x          (wr_x),
        .wr_y          (wr_y),
        .wr_type       (wr_type),
        .wr_vld        (wr_vld),
        .wr_ready      (wr_ready),
        .h_cnt         (h_cnt),
        .v_cnt         (v_cnt),
        .doodle_x      (doodle_x),
        .doodle_y      (doodle_y),
        .invincible    (invincible),
        .doodle_right  (doodle_right),
        .pixel_addr    (pixel_addr),
        .detect        (detect),
        .detect_doodle (detect_doodle)
`ifdef BSR_COLLISION_EN
        ,
        .collide       (collide),
        .collide_idx   (collide_idx)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int h; int v; int dx; int dy; int inv; int right; int en;
    } scan_t;

    typedef struct {
        int h; int v;
        logic [16:0] addr; logic [2:0] det; logic dd;
    } exp_t;

    scan_t stim_q[$];
    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;

    localparam int BGI = 62400;
    localparam int BGO = 115200;

    function automatic int plat_addr(int h, int v, int x, int y, int t);
        return (h - x) + (v - y) * 480 + 480 * 12 * t;
    endfunction

    function automatic int dood_addr(int h, int v, int dx, int dy, int col);
        return (h - dx) + (v - dy) * 480 + 480 * 60 + col;
    endfunction

    task automatic push_scan(int h, int v, int dx, int dy, int inv, int right,
                             int en, int addr, int det, int dd);
        scan_t s;
        exp_t  e;
        s = '{h, v, dx, dy, inv, right, en};
        e.h = h;
        e.v = v;
        e.addr = 17'(addr);
        e.det = 3'(det);
        e.dd = dd[0];
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic push_plain(int h, int v, int en, int addr, int det);
        push_scan(h, v, 900, 900, 0, 1, en, addr, det, 0);
    endtask

    task automatic drive(scan_t s);
        h_cnt = 10'(s.h);
        v_cnt = 10'(s.v);
        doodle_x = 10'(s.dx);
        doodle_y = 10'(s.dy);
        invincible = s.inv[0];
        doodle_right = s.right[0];
        game_en = s.en[0];
    endtask

    task automatic write_slot(int idx, int x, int y, int t, int vld);
        wr_en = 1'b1;
        wr_idx = 4'(idx);
        wr_x = 10'(x);
        wr_y = 10'(y);
        wr_type = 3'(t);
        wr_vld = vld[0];
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (pixel_addr !== 17'(BGO)) begin
            errors++;
            $display("FAIL reset_addr: got %0d expected %0d", pixel_addr, BGO);
        end
        checks++;
        if (detect !== 3'd5) begin
            errors++;
            $display("FAIL reset_detect: got %0d expected 5", detect);
        end
        checks++;
        if (detect_doodle !== 1'b0) begin
            errors++;
            $display("FAIL reset_dd: got %0b expected 0", detect_doodle);
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_wr_ready: got %0b expected 1", wr_ready);
        end
`ifdef BSR_COLLISION_EN
        checks++;
        if (collide !== 1'b0 || collide_idx !== 4'd0) begin
            errors++;
            $display("FAIL reset_collide: got %0b/%0d expected 0/0", collide, collide_idx);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_shadow();
        exp_t e;
        int n;
        write_slot(0, 300, 200, 3, 1);
        push_plain(300, 200, 1, BGI, 5);
        n = stim_q.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) drive(stim_q.pop_front());
            @(negedge clk);
            if (i > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (pixel_addr !== e.addr || detect !== e.det || detect_doodle !== e.dd) begin
                    errors++;
                    $display("FAIL shadow (%0d,%0d): got %0d/%0d/%0b expected %0d/%0d/%0b",
                             e.h, e.v, pixel_addr, detect, detect_doodle, e.addr, e.det, e.dd);
                end
            end
        end
    endtask

    task automatic test_platform();
        exp_t e;
        int n;
        frame();
        push_plain(300, 200, 1, 17280, 3);
        push_plain(332, 210, 1, plat_addr(332, 210, 300, 200, 3), 3);
        push_plain(333, 200, 1, BGI, 5);
        push_plain(300, 211, 1, BGI, 5);
        push_plain(299, 200, 1, BGI, 5);
        n = stim_q.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) drive(stim_q.pop_front());
            @(negedge clk);
            if (i > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (pixel_addr !== e.addr || detect !== e.det || detect_doodle !== e.dd) begin
                    errors++;
                    $display("FAIL platform (%0d,%0d): got %0d/%0d/%0b expected %0d/%0d/%0b",
                             e.h, e.v, pixel_addr, detect, detect_doodle, e.addr, e.det, e.dd);
                end
            end
        end
    endtask

    task automatic test_priority();
        exp_t e;
        int n;
        write_slot(2, 310, 245, 0, 1);
        write_slot(5, 320, 250, 4, 1);
        frame();
        push_plain(320, 250, 1, 2410, 0);
        push_plain(345, 258, 1, plat_addr(345, 258, 320, 250, 4), 4);
        push_plain(342, 255, 1, plat_addr(342, 255, 310, 245, 0), 0);
        n = stim_q.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) drive(stim_q.pop_front());
            @(negedge clk);
            if (i > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (pixel_addr !== e.addr || detect !== e.det || detect_doodle !== e.dd) begin
                    errors++;
                    $display("FAIL priority (%0d,%0d): got %0d/%0d/%0b expected %0d/%0d/%0b",
                             e.h, e.v, pixel_addr, detect, detect_doodle, e.addr, e.det, e.dd);
                end
            end
        end
    endtask

    task automatic test_drop();
        exp_t e;
        int n;
        frame_start = 1'b1;
        wr_en = 1'b1;
        wr_idx = 4'd1;
        wr_x = 10'd400;
        wr_y = 10'd300;
        wr_type = 3'd1;
        wr_vld = 1'b1;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL drop_wr_ready: got %0b expected 0", wr_ready);
        end
        @(negedge clk);
        frame_start = 1'b0;
        wr_en = 1'b0;
        frame();
        push_plain(400, 300, 1, BGI, 5);
        n = stim_q.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) drive(stim_q.pop_front());
            @(negedge clk);
            if (i > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (pixel_addr !== e.addr || detect !== e.det || detect_doodle !== e.dd) begin
                    errors++;
                    $display("FAIL drop (%0d,%0d): got %0d/%0d/%0b expected %0d/%0d/%0b",
                             e.h, e.v, pixel_addr, detect, detect_doodle, e.addr, e.det, e.dd);
                end
            end
        end
    endtask

    task automatic test_doodle();
        exp_t e;
        int n;
        frame();
        push_scan(300, 200, 300, 195, 0, 1, 1, 31200, 3, 1);
        push_scan(300, 200, 300, 195, 1, 1, 1, 31239, 3, 1);
        push_scan(300, 200, 300, 195, 0, 0, 1, 31278, 3, 1);
        push_scan(300, 200, 300, 195, 1, 0, 1, 31239, 3, 1);
        push_scan(338, 200, 300, 195, 0, 1, 1, dood_addr(338, 200, 300, 195, 0), 5, 1);
        push_scan(339, 200, 300, 195, 0, 1, 1, BGI, 5, 0);
        push_scan(300, 233, 300, 195, 0, 1, 1, dood_addr(300, 233, 300, 195, 0), 5, 1);
        push_scan(300, 234, 300, 195, 0, 1, 1, BGI, 5, 0);
        push_scan(300, 200, 300, 195, 0, 1, 0, BGI, 5, 0);
        n = stim_q.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) drive(stim_q.pop_front());
            @(negedge clk);
            if (i > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (pixel_addr !== e.addr || detect !== e.det || detect_doodle !== e.dd) begin
                    errors++;
                    $display("FAIL doodle (%0d,%0d): got %0d/%0d/%0b expected %0d/%0d/%0b",
                             e.h, e.v, pixel_addr, detect, detect_doodle, e.addr, e.det, e.dd);
                end
            end
        end
        game_en = 1'b1;
        doodle_x = 10'd900;
        doodle_y = 10'd900;
`ifdef BSR_COLLISION_EN
        checks++;
        if (collide !== 1'b1 || collide_idx !== 4'd0) begin
            errors++;
            $display("FAIL collide_set: got %0b/%0d expected 1/0", collide, collide_idx);
        end
        frame();
        checks++;
        if (collide !== 1'b0 || collide_idx !== 4'd0) begin
            errors++;
            $display("FAIL collide_clear: got %0b/%0d expected 0/0", collide, collide_idx);
        end
`endif
    endtask

    task automatic test_bounds();
        exp_t e;
        int n;
        write_slot(3, 90, 100, 2, 1);
        frame();
        push_plain(100, 105, 1, BGO, 2);
        push_plain(300, 200, 0, BGI, 5);
        push_plain(100, 105, 0, BGO, 5);
        push_plain(199, 200, 1, BGO, 5);
        push_plain(200, 200, 1, BGI, 5);
        push_plain(440, 200, 1, BGI, 5);
        push_plain(441, 200, 1, BGO, 5);
        push_scan(160, 105, 150, 100, 0, 1, 1, BGO, 5, 0);
        n = stim_q.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) drive(stim_q.pop_front());
            @(negedge clk);
            if (i > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (pixel_addr !== e.addr || detect !== e.det || detect_doodle !== e.dd) begin
                    errors++;
                    $display("FAIL bounds (%0d,%0d): got %0d/%0d/%0b expected %0d/%0d/%0b",
                             e.h, e.v, pixel_addr, detect, detect_doodle, e.addr, e.det, e.dd);
                end
            end
        end
        game_en = 1'b1;
    endtask

    task automatic test_wrap();
        exp_t e;
        int n;
        write_slot(4, 1020, 0, 1, 1);
        write_slot(6, 360, 300, 6, 1);
        frame();
        push_plain(5, 5, 1, BGO, 5);
        push_plain(1020, 0, 1, BGO, 1);
        push_plain(1023, 5, 1, BGO, 1);
        push_plain(360, 300, 1, BGI, 5);
        n = stim_q.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) drive(stim_q.pop_front());
            @(negedge clk);
            if (i > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (pixel_addr !== e.addr || detect !== e.det || detect_doodle !== e.dd) begin
                    errors++;
                    $display("FAIL wrap (%0d,%0d): got %0d/%0d/%0b expected %0d/%0d/%0b",
                             e.h, e.v, pixel_addr, detect, detect_doodle, e.addr, e.det, e.dd);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int n;
        h_cnt = 10'd300;
        v_cnt = 10'd200;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (pixel_addr !== 17'(BGO) || detect !== 3'd5 || detect_doodle !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got %0d/%0d/%0b expected %0d/5/0",
                     pixel_addr, detect, detect_doodle, BGO);
        end
        @(negedge clk);
        rst = 1'b0;
        frame();
        push_plain(300, 200, 1, BGI, 5);
        push_plain(100, 105, 1, BGO, 5);
        n = stim_q.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) drive(stim_q.pop_front());
            @(negedge clk);
            if (i > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (pixel_addr !== e.addr || detect !== e.det || detect_doodle !== e.dd) begin
                    errors++;
                    $display("FAIL reset_clear (%0d,%0d): got %0d/%0d/%0b expected %0d/%0d/%0b",
                             e.h, e.v, pixel_addr, detect, detect_doodle, e.addr, e.det, e.dd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_shadow();
        test_platform();
        test_priority();
        test_drop();
        test_doodle();
        test_bounds();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
